// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Central stall/flush sequencer for a 5-stage RV32I pipeline (IF ID EX MEM WB).
// It shadows the destination registers of EX/MEM/WB in a small scoreboard,
// detects RAW hazards against the instruction sitting in ID, and drives the
// freeze/bubble/squash controls of the pipeline registers. It also owns the
// data-memory wait handshake and raises a sticky fault on a memory timeout.
//
// Ports
//   clk, rst            : rising-edge clock, synchronous active-high reset
//   id_valid            : ID holds a real instruction
//   id_rs1_addr/rs2_addr: ID source registers (0 when unused)
//   id_rd_addr          : ID destination register
//   id_do_write_back    : ID instruction writes rd
//   id_is_load          : ID instruction is a load
//   ex_redirect         : EX resolved a taken branch/jump this cycle
//   mem_req, mem_ready  : MEM-stage access request / completion
//   stall_if..stall_mem : hold the corresponding pipeline register
//   bubble_ex, bubble_wb: load a NOP into ID/EX, MEM/WB
//   flush_if, flush_id  : squash IF/ID, ID/EX
//   mem_fault           : sticky memory timeout
//   state               : FSM state, 0=RUN 1=MEM_WAIT 2=FAULT
module pipeline_hazard_ctrl #(
   parameter int FORWARDING  = 1,
   parameter int MEM_TIMEOUT = 255,
   parameter int TO_WIDTH    = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       id_valid,
   input  logic [4:0] id_rs1_addr,
   input  logic [4:0] id_rs2_addr,
   input  logic [4:0] id_rd_addr,
   input  logic       id_do_write_back,
   input  logic       id_is_load,
   input  logic       ex_redirect,
   input  logic       mem_req,
   input  logic       mem_ready,
   output logic       stall_if,
   output logic       stall_id,
   output logic       stall_ex,
   output logic       stall_mem,
   output logic       bubble_ex,
   output logic       bubble_wb,
   output logic       flush_if,
   output logic       flush_id,
   output logic       mem_fault,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      FAULT    = 2'd2
   } state_t;

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       wb;
      logic       load;
   } slot_t;

   localparam logic [TO_WIDTH-1:0] TO_LIMIT = TO_WIDTH'(MEM_TIMEOUT);
   localparam bit                  FWD      = (FORWARDING != 0);

   state_t              cur;
   logic [TO_WIDTH-1:0] wait_cnt;
   logic                fault_q;
   slot_t               slot_ex;
   slot_t               slot_mem;
   slot_t               slot_wb;

   logic ex_hit;
   logic mem_hit;
   logic wb_hit;
   logic hazard;
   logic freeze;

   // A source collides with a slot only if it names a real register that the
   // slot's instruction is going to write.
   function automatic logic src_hit(input logic [4:0] src, input slot_t s);
      return (src != 5'd0) && s.valid && s.wb && (s.rd == src);
   endfunction

   // RAW detection; with the bypass only a load still in EX cannot be forwarded.
   always_comb begin
      ex_hit  = src_hit(id_rs1_addr, slot_ex)  | src_hit(id_rs2_addr, slot_ex);
      mem_hit = src_hit(id_rs1_addr, slot_mem) | src_hit(id_rs2_addr, slot_mem);
      wb_hit  = src_hit(id_rs1_addr, slot_wb)  | src_hit(id_rs2_addr, slot_wb);
      hazard  = FWD ? (ex_hit & slot_ex.load) : (ex_hit | mem_hit | wb_hit);
   end

   // Whole-pipeline freeze: outstanding memory access or a latched fault.
   always_comb begin
      case (cur)
         RUN:      freeze = mem_req & ~mem_ready;
         MEM_WAIT: freeze = ~mem_ready;
         FAULT:    freeze = 1'b1;
         default:  freeze = 1'b1;
      endcase
   end

   // Control outputs; priority freeze > redirect > hazard, all forced low in reset.
   always_comb begin
      stall_if  = 1'b0;
      stall_id  = 1'b0;
      stall_ex  = 1'b0;
      stall_mem = 1'b0;
      bubble_ex = 1'b0;
      bubble_wb = 1'b0;
      flush_if  = 1'b0;
      flush_id  = 1'b0;
      if (rst) begin
         stall_if = 1'b0;
      end else if (freeze) begin
         stall_if  = 1'b1;
         stall_id  = 1'b1;
         stall_ex  = 1'b1;
         stall_mem = 1'b1;
         bubble_wb = 1'b1;
      end else if (ex_redirect) begin
         flush_if = 1'b1;
         flush_id = 1'b1;
      end else if (hazard && id_valid) begin
         stall_if  = 1'b1;
         stall_id  = 1'b1;
         bubble_ex = 1'b1;
      end else begin
         stall_if = 1'b0;
      end
   end

   assign mem_fault = fault_q & ~rst;
   assign state     = cur;

   // FSM, wait counter, sticky fault and scoreboard shift register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cur      <= RUN;
         wait_cnt <= '0;
         fault_q  <= 1'b0;
         slot_ex  <= '0;
         slot_mem <= '0;
         slot_wb  <= '0;
      end else begin
         // Scoreboard follows the pipeline registers: frozen while EX/MEM holds.
         if (!stall_ex) begin
            slot_wb  <= slot_mem;
            slot_mem <= slot_ex;
            if (bubble_ex || flush_id || !id_valid) begin
               slot_ex <= '0;
            end else begin
               slot_ex <= {1'b1, id_rd_addr, id_do_write_back, id_is_load};
            end
         end
         case (cur)
            RUN: begin
               if (mem_req && !mem_ready) begin
                  cur      <= MEM_WAIT;
                  wait_cnt <= TO_WIDTH'(1);
               end
            end
            MEM_WAIT: begin
               if (mem_ready) begin
                  cur      <= RUN;
                  wait_cnt <= '0;
               end else if (wait_cnt == TO_LIMIT) begin
                  cur     <= FAULT;
                  fault_q <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + TO_WIDTH'(1);
               end
            end
            FAULT: begin
               fault_q <= 1'b1;
            end
            default: begin
               cur      <= RUN;
               wait_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl. Two instances share inputs:
// u_a (FORWARDING=1, MEM_TIMEOUT=6) and u_b (FORWARDING=0, MEM_TIMEOUT=3).
// A behavioural model (list of in-flight instructions + mode/counter) predicts
// every output each cycle; scenario tasks add fixed expectations on top.
module tb_pipeline_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_valid;
   logic [4:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
   logic       id_do_write_back, id_is_load;
   logic       ex_redirect, mem_req, mem_ready;

   logic stall_if_a, stall_id_a, stall_ex_a, stall_mem_a, bubble_ex_a, bubble_wb_a;
   logic flush_if_a, flush_id_a, mem_fault_a;
   logic [1:0] state_a;
   logic stall_if_b, stall_id_b, stall_ex_b, stall_mem_b, bubble_ex_b, bubble_wb_b;
   logic flush_if_b, flush_id_b, mem_fault_b;
   logic [1:0] state_b;

   // bit order: {state[1:0], stall_if, stall_id, stall_ex, stall_mem,
   //             bubble_ex, bubble_wb, flush_if, flush_id, mem_fault}
   logic [10:0] obs_a, obs_b, exp_a, exp_b;
   assign obs_a = {state_a, stall_if_a, stall_id_a, stall_ex_a, stall_mem_a,
                   bubble_ex_a, bubble_wb_a, flush_if_a, flush_id_a, mem_fault_a};
   assign obs_b = {state_b, stall_if_b, stall_id_b, stall_ex_b, stall_mem_b,
                   bubble_ex_b, bubble_wb_b, flush_if_b, flush_id_b, mem_fault_b};

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.FORWARDING(1), .MEM_TIMEOUT(6), .TO_WIDTH(8)) u_a (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1_addr(id_rs1_addr),
      .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
      .id_do_write_back(id_do_write_back), .id_is_load(id_is_load),
      .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_ready(mem_ready),
      .stall_if(stall_if_a), .stall_id(stall_id_a), .stall_ex(stall_ex_a),
      .stall_mem(stall_mem_a), .bubble_ex(bubble_ex_a), .bubble_wb(bubble_wb_a),
      .flush_if(flush_if_a), .flush_id(flush_id_a), .mem_fault(mem_fault_a),
      .state(state_a));

   pipeline_hazard_ctrl #(.FORWARDING(0), .MEM_TIMEOUT(3), .TO_WIDTH(4)) u_b (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1_addr(id_rs1_addr),
      .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
      .id_do_write_back(id_do_write_back), .id_is_load(id_is_load),
      .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_ready(mem_ready),
      .stall_if(stall_if_b), .stall_id(stall_id_b), .stall_ex(stall_ex_b),
      .stall_mem(stall_mem_b), .bubble_ex(bubble_ex_b), .bubble_wb(bubble_wb_b),
      .flush_if(flush_if_b), .flush_id(flush_id_b), .mem_fault(mem_fault_b),
      .state(state_b));

   // ---------------- reference model ----------------
   int         fwd_cfg [2] = '{1, 0};
   int         tmo_cfg [2] = '{6, 3};
   int         m_mode  [2];            // 0 run, 1 waiting on memory, 2 faulted
   int         m_cnt   [2];            // wait cycles seen so far
   bit         m_v     [2][3];         // in-flight instructions: 0=EX 1=MEM 2=WB
   logic [4:0] m_rd    [2][3];
   bit         m_wb    [2][3];
   bit         m_ld    [2][3];

   function automatic logic [10:0] model_out(input int m);
      logic [8:0] c;
      bit haz, frz;
      haz = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (m_v[m][k] && m_wb[m][k] && (fwd_cfg[m] == 0 || (k == 0 && m_ld[m][k]))) begin
            if ((id_rs1_addr != 5'd0 && id_rs1_addr == m_rd[m][k]) ||
                (id_rs2_addr != 5'd0 && id_rs2_addr == m_rd[m][k]))
               haz = 1'b1;
         end
      end
      frz = (m_mode[m] == 2) || (m_mode[m] == 1 && !mem_ready) ||
            (m_mode[m] == 0 && mem_req && !mem_ready);
      if (rst)                    c = 9'b000000000;
      else if (frz)               c = (m_mode[m] == 2) ? 9'b111101001 : 9'b111101000;
      else if (ex_redirect)       c = 9'b000000110;
      else if (haz && id_valid)   c = 9'b110010000;
      else                        c = 9'b000000000;
      return {2'(m_mode[m]), c};
   endfunction

   task automatic model_tick();
      logic [10:0] o;
      for (int m = 0; m < 2; m++) begin
         if (rst) begin
            m_mode[m] = 0;
            m_cnt[m]  = 0;
            for (int k = 0; k < 3; k++) m_v[m][k] = 1'b0;
         end else begin
            o = model_out(m);
            if (!o[6]) begin
               for (int k = 2; k > 0; k--) begin
                  m_v[m][k] = m_v[m][k-1]; m_rd[m][k] = m_rd[m][k-1];
                  m_wb[m][k] = m_wb[m][k-1]; m_ld[m][k] = m_ld[m][k-1];
               end
               m_v[m][0]  = id_valid && !o[4] && !o[1];
               m_rd[m][0] = id_rd_addr; m_wb[m][0] = id_do_write_back; m_ld[m][0] = id_is_load;
            end
            if (m_mode[m] == 0) begin
               if (mem_req && !mem_ready) begin m_mode[m] = 1; m_cnt[m] = 1; end
            end else if (m_mode[m] == 1) begin
               if (mem_ready) begin m_mode[m] = 0; m_cnt[m] = 0; end
               else if (m_cnt[m] == tmo_cfg[m]) m_mode[m] = 2;
               else m_cnt[m] = m_cnt[m] + 1;
            end
         end
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic set_id(input bit v, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] rd, input bit wb, input bit ld);
      id_valid = v; id_rs1_addr = r1; id_rs2_addr = r2;
      id_rd_addr = rd; id_do_write_back = wb; id_is_load = ld;
   endtask

   task automatic idle_inputs();
      set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      ex_redirect = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
   endtask

   task automatic advance();
      @(posedge clk);
      model_tick();
      #1;
   endtask

   task automatic apply_reset();
      idle_inputs();
      rst = 1'b1;
      advance();
      rst = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      @(negedge clk);
      total += 2;
      if (obs_a[8:0] !== 9'd0) begin bad++; $display("FAIL reset_ctrl_a got=%b want=%b", obs_a[8:0], 9'd0); end
      if (obs_b[8:0] !== 9'd0) begin bad++; $display("FAIL reset_ctrl_b got=%b want=%b", obs_b[8:0], 9'd0); end
      advance();
      rst = 1'b0;
      @(negedge clk);
      total += 2;
      if (obs_a !== 11'd0) begin bad++; $display("FAIL reset_idle_a got=%b want=%b", obs_a, 11'd0); end
      if (obs_b !== 11'd0) begin bad++; $display("FAIL reset_idle_b got=%b want=%b", obs_b, 11'd0); end
      advance();
   endtask

   task automatic test_load_use();
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         if (i == 0) set_id(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1);   // lw x5,0(x1)
         else        set_id(1'b1, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0);   // add x6,x5,x1
         @(negedge clk);
         exp_a = model_out(0); exp_b = model_out(1);
         total += 2;
         if (obs_a !== exp_a) begin bad++; $display("FAIL load_use_a cyc=%0d got=%b want=%b", i, obs_a, exp_a); end
         if (obs_b !== exp_b) begin bad++; $display("FAIL load_use_b cyc=%0d got=%b want=%b", i, obs_b, exp_b); end
         if (i == 1) begin
            total++;
            if (obs_a[8:0] !== 9'b110010000) begin bad++; $display("FAIL load_use_stall got=%b want=%b", obs_a[8:0], 9'b110010000); end
         end
         if (i == 2) begin
            total++;
            if (obs_a[8:0] !== 9'd0) begin bad++; $display("FAIL load_use_release got=%b want=%b", obs_a[8:0], 9'd0); end
         end
         advance();
      end
   endtask

   task automatic test_raw_nonload();
      int n_a = 0, n_b = 0;
      apply_reset();
      for (int i = 0; i < 6; i++) begin
         if (i == 0) set_id(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0);   // add x5
         else        set_id(1'b1, 5'd5, 5'd2, 5'd7, 1'b1, 1'b0);   // sub x7,x5,x2
         @(negedge clk);
         exp_a = model_out(0); exp_b = model_out(1);
         total += 2;
         if (obs_a !== exp_a) begin bad++; $display("FAIL raw_a cyc=%0d got=%b want=%b", i, obs_a, exp_a); end
         if (obs_b !== exp_b) begin bad++; $display("FAIL raw_b cyc=%0d got=%b want=%b", i, obs_b, exp_b); end
         n_a += int'(stall_if_a);
         n_b += int'(stall_if_b);
         advance();
      end
      total += 2;
      if (n_a != 0) begin bad++; $display("FAIL raw_fwd_stalls got=%0d want=0", n_a); end
      if (n_b != 3) begin bad++; $display("FAIL raw_nofwd_stalls got=%0d want=3", n_b); end
   endtask

   task automatic test_x0();
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         case (i)
            0:       set_id(1'b1, 5'd3, 5'd0, 5'd0, 1'b1, 1'b1);   // load into x0
            1:       set_id(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 1'b0);
            default: set_id(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
         endcase
         @(negedge clk);
         exp_a = model_out(0); exp_b = model_out(1);
         total += 2;
         if (obs_a !== exp_a) begin bad++; $display("FAIL x0_a cyc=%0d got=%b want=%b", i, obs_a, exp_a); end
         if (obs_b !== exp_b) begin bad++; $display("FAIL x0_b cyc=%0d got=%b want=%b", i, obs_b, exp_b); end
         if (i > 0) begin
            total++;
            if ({stall_if_a, stall_if_b} !== 2'b00) begin bad++; $display("FAIL x0_nostall cyc=%0d got=%b want=00", i, {stall_if_a, stall_if_b}); end
         end
         advance();
      end
   endtask

   task automatic test_redirect_hazard();
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         ex_redirect = (i == 1);
         case (i)
            0:       set_id(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1);
            1:       set_id(1'b1, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0);
            default: set_id(1'b0, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0);
         endcase
         @(negedge clk);
         exp_a = model_out(0); exp_b = model_out(1);
         total += 2;
         if (obs_a !== exp_a) begin bad++; $display("FAIL redir_a cyc=%0d got=%b want=%b", i, obs_a, exp_a); end
         if (obs_b !== exp_b) begin bad++; $display("FAIL redir_b cyc=%0d got=%b want=%b", i, obs_b, exp_b); end
         if (i == 1) begin
            total += 2;
            if (obs_a[8:0] !== 9'b000000110) begin bad++; $display("FAIL redir_prio_a got=%b want=%b", obs_a[8:0], 9'b000000110); end
            if (obs_b[8:0] !== 9'b000000110) begin bad++; $display("FAIL redir_prio_b got=%b want=%b", obs_b[8:0], 9'b000000110); end
         end
         if (i == 2) begin
            total++;
            if ({obs_a[8:0], obs_b[8:0]} !== 18'd0) begin bad++; $display("FAIL redir_after got=%b want=0", {obs_a[8:0], obs_b[8:0]}); end
         end
         advance();
      end
      ex_redirect = 1'b0;
   endtask

   task automatic test_mem_wait();
      int n_wait = 0, n_frz = 0;
      apply_reset();
      for (int i = 0; i < 7; i++) begin
         if (i == 0) set_id(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1);
         else        set_id(1'b1, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0);
         mem_req   = (i >= 1 && i <= 5);
         mem_ready = (i == 5);
         @(negedge clk);
         exp_a = model_out(0); exp_b = model_out(1);
         total += 2;
         if (obs_a !== exp_a) begin bad++; $display("FAIL memwait_a cyc=%0d got=%b want=%b", i, obs_a, exp_a); end
         if (obs_b !== exp_b) begin bad++; $display("FAIL memwait_b cyc=%0d got=%b want=%b", i, obs_b, exp_b); end
         if (state_a == 2'd1) n_wait++;
         if (obs_a[8:0] == 9'b111101000) n_frz++;
         if (i == 5) begin
            total++;
            if (obs_a[8:0] !== 9'b110010000) begin bad++; $display("FAIL memwait_release got=%b want=%b", obs_a[8:0], 9'b110010000); end
         end
         advance();
      end
      total += 2;
      if (n_wait != 4) begin bad++; $display("FAIL memwait_state_cycles got=%0d want=4", n_wait); end
      if (n_frz != 4)  begin bad++; $display("FAIL memwait_frozen_cycles got=%0d want=4", n_frz); end
   endtask

   task automatic test_timeout();
      apply_reset();
      for (int i = 0; i < 12; i++) begin
         set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
         mem_req   = 1'b1;
         mem_ready = (i >= 9);
         @(negedge clk);
         exp_a = model_out(0); exp_b = model_out(1);
         total += 2;
         if (obs_a !== exp_a) begin bad++; $display("FAIL timeout_a cyc=%0d got=%b want=%b", i, obs_a, exp_a); end
         if (obs_b !== exp_b) begin bad++; $display("FAIL timeout_b cyc=%0d got=%b want=%b", i, obs_b, exp_b); end
         if (i >= 4) begin
            total++;
            if ({state_b, mem_fault_b} !== 3'b101) begin bad++; $display("FAIL timeout_fault_b cyc=%0d got=%b want=101", i, {state_b, mem_fault_b}); end
         end
         if (i >= 7) begin
            total++;
            if ({state_a, mem_fault_a} !== 3'b101) begin bad++; $display("FAIL timeout_fault_a cyc=%0d got=%b want=101", i, {state_a, mem_fault_a}); end
         end
         advance();
      end
      idle_inputs();
      rst = 1'b1;
      @(negedge clk);
      total += 2;
      if (obs_a[8:0] !== 9'd0) begin bad++; $display("FAIL fault_rst_a got=%b want=0", obs_a[8:0]); end
      if (obs_b[8:0] !== 9'd0) begin bad++; $display("FAIL fault_rst_b got=%b want=0", obs_b[8:0]); end
      advance();
      rst = 1'b0;
      @(negedge clk);
      total += 2;
      if (obs_a !== 11'd0) begin bad++; $display("FAIL fault_cleared_a got=%b want=0", obs_a); end
      if (obs_b !== 11'd0) begin bad++; $display("FAIL fault_cleared_b got=%b want=0", obs_b); end
      advance();
   endtask

   task automatic test_random();
      apply_reset();
      for (int i = 0; i < 600; i++) begin
         rst = ($urandom_range(0, 63) == 0);
         set_id($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
         ex_redirect = ($urandom_range(0, 7) == 0);
         mem_req     = ($urandom_range(0, 3) == 0);
         mem_ready   = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         exp_a = model_out(0); exp_b = model_out(1);
         total += 2;
         if (obs_a !== exp_a) begin bad++; $display("FAIL random_a cyc=%0d got=%b want=%b", i, obs_a, exp_a); end
         if (obs_b !== exp_b) begin bad++; $display("FAIL random_b cyc=%0d got=%b want=%b", i, obs_b, exp_b); end
         advance();
      end
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_load_use();
      test_raw_nonload();
      test_x0();
      test_redirect_hazard();
      test_mem_wait();
      test_timeout();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
